hero_write_rx: RTL and testbench
================================

# hero_write_rx

Receive stage directly downstream of the hero write bus (`hero_write_t`).
- Collects VALID/DONE beats into a store-and-forward buffer.
- Commits a transaction to the output only when its DONE beat arrives.
- Drains committed beats on a valid/ready stream with a last flag.
- The hero bus has no backpressure, so on overflow or an oversize transaction the block rewinds the buffer, drops the whole transaction and flags it.

## Interface
Parameters:
- `DEPTH`, 16: buffer entries; power of two, ≥ 2.
- `MAX_BEATS`, 8: maximum beats per transaction, including the DONE beat; must be ≤ `DEPTH`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `hero_in`  in  `hero_write_t`  hero write bus.
  - `cycle_type`, `wdat` and `clk_en` are consumed.
  - `another_type_reference` is not consumed.
- `out_vld`  out  1  committed beat available.
- `out_rdy`  in  1  consumer accepts beat.
- `out_dat`  out  `HERO_WIDTH`  beat data.
- `out_last`  out  1  final beat of transaction.
- `drop_pulse`  out  1  one-cycle pulse: transaction dropped.
- `protocol_err`  out  1  one-cycle pulse: undefined `cycle_type` seen.
- `fill`  out  `$clog2(DEPTH)+1`  occupied entries, committed and uncommitted.
- `txn_count`  out  16  committed transactions (see Configuration).
- `drop_count`  out  16  dropped transactions (see Configuration).

## Operation
- Beat qualification:
  - A beat is present when `clk_en`=1 and `cycle_type` ≠ IDLE.
  - When `clk_en`=0 the input is ignored for every type.
  - Undefined `cycle_type` with `clk_en`=1: beat ignored, `protocol_err` pulses, state unchanged.
- Pointers:
  - `wr_ptr`, `commit_ptr`, `rd_ptr`, each with `$clog2(DEPTH)+1` bits; the extra MSB disambiguates full from empty.
  - Entry = {last, wdat}.
- FSM states: IDLE, COLLECT, DROP.
  - IDLE + VALID: write beat (last=0), beat_cnt=1, go to COLLECT.
  - IDLE + DONE: write beat (last=1), `commit_ptr`←`wr_ptr`+1, stay in IDLE (single-beat transaction).
  - COLLECT + VALID: write beat, beat_cnt+1.
  - COLLECT + DONE: write last beat, commit, go to IDLE.
  - DROP: discard all beats; DONE returns to IDLE. No pulse is issued in DROP.
- Drop condition: a beat arrives in IDLE or COLLECT while the buffer is full, or while beat_cnt == `MAX_BEATS`.
  - The offending beat is not written.
  - `wr_ptr`←`commit_ptr`, `drop_pulse`=1, `drop_count` increments.
  - Next state is DROP, or IDLE if the offending beat was DONE.
- Full/empty:
  - Full: (`wr_ptr` − `rd_ptr`) == `DEPTH`.
  - `out_vld` = (`rd_ptr` ≠ `commit_ptr`).
  - Uncommitted beats are never visible at the output.
- Output:
  - Show-ahead: `out_dat`/`out_last` reflect entry[`rd_ptr`] whenever `out_vld`=1.
  - Pop on `out_vld`&`out_rdy`. `out_dat` is held stable while `out_vld`=1 and `out_rdy`=0.
- Pointer arithmetic wraps modulo 2·`DEPTH`.

## Timing
- Reset values:
  - `out_vld`=0, `out_last`=0, `out_dat`=0, `drop_pulse`=0, `protocol_err`=0, `fill`=0, counters=0.
  - FSM=IDLE, all pointers=0.
- Reset asserted mid-transaction: all buffered data, committed or not, is discarded.
- Latency: DONE accepted in cycle N → `out_vld`=1 in cycle N+1 (if the buffer was previously empty).
- Full is evaluated on registered pointers at cycle start.
  - A pop in the same cycle as a push frees space only from the next cycle.
  - Hence a push to a full buffer drops even if a pop occurs that cycle.
- `drop_pulse` and `protocol_err` are registered and assert the cycle after the causing beat.
- Simultaneous commit and pop are both honoured in one cycle.

## Configuration
- `HERO_WRITE_RX_STATS_EN` defined:
  - `txn_count` increments per commit.
  - `drop_count` increments per drop.
  - Both are 16-bit and saturate at 0xFFFF.
- Not defined: counters are not implemented; `txn_count` and `drop_count` are tied to 0. All other behaviour is identical.

## Structure
- Shared package (alongside `hero_write_t`, `CYCLE_TYPE_E`, `HERO_WIDTH`):
  - `hero_rx_state_e` (IDLE/COLLECT/DROP).
  - `hero_rx_entry_t` {logic last; logic [HERO_WIDTH-1:0] dat}.
- Sub-module `hero_write_rx_mem`: `DEPTH`×`hero_rx_entry_t` register array with one write port and one asynchronous read port.
- FSM, pointers and counters live in `hero_write_rx`.

## Test plan
- Single DONE beat, wdat=0x123456789, `out_rdy`=1 → next cycle `out_vld`=1, `out_dat`=0x123456789, `out_last`=1; then `out_vld`=0.
- VALID×3 then DONE (wdat 1..4), with `clk_en`=0 on interleaved cycles carrying VALID → exactly 4 beats out, data 1,2,3,4, `out_last` only on 4; `out_vld` stays 0 until DONE is accepted.
- `DEPTH`=16, `out_rdy`=0, two committed 8-beat transactions, then VALID → `drop_pulse` fires, `fill` stays 16; subsequent beats discarded through DONE; then `out_rdy`=1 → 16 beats out, no partial data.
- 9-beat transaction with `MAX_BEATS`=8 → drop on beat 9 (DONE), FSM returns to IDLE, `fill` back to pre-transaction value, `drop_count`=1 (with STATS_EN).
- `clk_en`=1 with undefined `cycle_type`=3 mid-COLLECT → `protocol_err` pulses once; the transaction completes normally with the correct beat count.
- Reset asserted after 2 of 4 beats with committed data pending → all outputs at reset values at once; the next DONE-only transaction is delivered correctly.

Source files
------------

// File: rtl/hero_write_rx_pkg.sv
// Shared types for the hero write bus and the hero_write_rx receive stage.
package hero_write_rx_pkg;

    localparam int HERO_WIDTH = 36;

    typedef enum logic [1:0] {
        CYCLE_IDLE  = 2'd0,
        CYCLE_VALID = 2'd1,
        CYCLE_DONE  = 2'd2
    } CYCLE_TYPE_E;

    typedef struct packed {
        CYCLE_TYPE_E           cycle_type;
        logic [HERO_WIDTH-1:0] wdat;
        logic                  clk_en;
        logic [7:0]            another_type_reference;
    } hero_write_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DROP    = 2'd2
    } hero_rx_state_e;

    typedef struct packed {
        logic                  last;
        logic [HERO_WIDTH-1:0] dat;
    } hero_rx_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hero_write_rx_mem.sv
// Entry storage for hero_write_rx: one synchronous write port, one asynchronous read port.
module hero_write_rx_mem
    import hero_write_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  hero_rx_entry_t wentry,
    input  logic [AW-1:0]  raddr,
    output hero_rx_entry_t rentry
);

    hero_rx_entry_t mem [DEPTH];

    // No reset: the top masks the read data whenever nothing is committed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wentry;
        end
    end

    assign rentry = mem[raddr];

endmodule

// File: rtl/hero_write_rx.sv
// Store-and-forward receiver for the hero write bus; drops whole transactions on overflow.
// Optional statistics counters are built when HERO_WRITE_RX_STATS_EN is defined.
module hero_write_rx
    import hero_write_rx_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int MAX_BEATS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  hero_write_t              hero_in,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [HERO_WIDTH-1:0]    out_dat,
    output logic                     out_last,
    output logic                     drop_pulse,
    output logic                     protocol_err,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [15:0]              txn_count,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    hero_rx_state_e state, state_nxt;
    logic [PW-1:0]  wr_ptr, commit_ptr, rd_ptr;
    logic [CW-1:0]  beat_cnt, beat_cnt_nxt;
    logic           is_valid, is_done, is_beat, bad_type;
    logic           full, pop;
    logic           do_write, do_commit, do_drop;
    hero_rx_entry_t rd_entry;
    logic           unused_hero;

    assign unused_hero = ^hero_in.another_type_reference;

    // Full uses the registered pointers, so a same-cycle pop does not make room.
    assign full    = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign fill    = wr_ptr - rd_ptr;
    assign out_vld = (rd_ptr != commit_ptr);
    assign pop     = out_vld && out_rdy;

    always_comb begin
        is_valid     = hero_in.clk_en && (hero_in.cycle_type == CYCLE_VALID);
        is_done      = hero_in.clk_en && (hero_in.cycle_type == CYCLE_DONE);
        is_beat      = is_valid || is_done;
        bad_type     = hero_in.clk_en &&
                       !(hero_in.cycle_type inside {CYCLE_IDLE, CYCLE_VALID, CYCLE_DONE});
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        do_write     = 1'b0;
        do_commit    = 1'b0;
        do_drop      = 1'b0;
        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (is_beat) begin
                    if (full || (beat_cnt == CW'(MAX_BEATS))) begin
                        do_drop      = 1'b1;
                        beat_cnt_nxt = '0;
                        state_nxt    = is_done ? ST_IDLE : ST_DROP;
                    end else if (is_done) begin
                        do_write     = 1'b1;
                        do_commit    = 1'b1;
                        beat_cnt_nxt = '0;
                        state_nxt    = ST_IDLE;
                    end else begin
                        do_write     = 1'b1;
                        beat_cnt_nxt = beat_cnt + CW'(1);
                        state_nxt    = ST_COLLECT;
                    end
                end
            end
            ST_DROP: begin
                if (is_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            rd_ptr       <= '0;
            drop_pulse   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            beat_cnt     <= beat_cnt_nxt;
            drop_pulse   <= do_drop;
            protocol_err <= bad_type;
            // A drop rewinds to the last commit point, discarding the partial transaction.
            if (do_drop) begin
                wr_ptr <= commit_ptr;
            end else if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_commit) begin
                commit_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    hero_write_rx_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (do_write),
        .waddr  (wr_ptr[AW-1:0]),
        .wentry ('{last: is_done, dat: hero_in.wdat}),
        .raddr  (rd_ptr[AW-1:0]),
        .rentry (rd_entry)
    );

    assign out_dat  = out_vld ? rd_entry.dat : '0;
    assign out_last = out_vld && rd_entry.last;

`ifdef HERO_WRITE_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count  <= '0;
            drop_count <= '0;
        end else begin
            if (do_commit) begin
                txn_count <= sat_inc16(txn_count);
            end
            if (do_drop) begin
                drop_count <= sat_inc16(drop_count);
            end
        end
    end
`else
    assign txn_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_hero_write_rx.sv
// Directed bench for hero_write_rx (DEPTH=16, MAX_BEATS=8).
module tb_hero_write_rx;
    import hero_write_rx_pkg::*;

`ifdef HERO_WRITE_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    hero_write_t           hero_in;
    logic                  out_vld;
    logic                  out_rdy;
    logic [HERO_WIDTH-1:0] out_dat;
    logic                  out_last;
    logic                  drop_pulse;
    logic                  protocol_err;
    logic [4:0]            fill;
    logic [15:0]           txn_count;
    logic [15:0]           drop_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hero_write_rx #(
        .DEPTH     (16),
        .MAX_BEATS (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hero_in      (hero_in),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_dat      (out_dat),
        .out_last     (out_last),
        .drop_pulse   (drop_pulse),
        .protocol_err (protocol_err),
        .fill         (fill),
        .txn_count    (txn_count),
        .drop_count   (drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one bus cycle, then land 1 time unit after the capturing edge.
    task automatic drive(input CYCLE_TYPE_E ct, input logic [HERO_WIDTH-1:0] d, input logic en);
        hero_in.cycle_type = ct;
        hero_in.wdat       = d;
        hero_in.clk_en     = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(CYCLE_IDLE, '0, 1'b1);
    endtask

    initial begin
        rst_n   = 1'b0;
        out_rdy = 1'b0;
        hero_in = '{cycle_type: CYCLE_IDLE, wdat: '0, clk_en: 1'b0, another_type_reference: 8'h5C};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset state
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_fill", fill, 0);
        chk("rst_txn_count", txn_count, 0);
        chk("rst_drop_count", drop_count, 0);

        // single DONE beat, one-cycle latency
        out_rdy = 1'b1;
        drive(CYCLE_DONE, 36'h123456789, 1'b1);
        chk("single_vld", out_vld, 1);
        chk("single_dat", out_dat, 36'h123456789);
        chk("single_last", out_last, 1);
        chk("single_fill", fill, 1);
        idle();
        chk("single_vld_after", out_vld, 0);
        chk("single_fill_after", fill, 0);

        // VALID x3 + DONE with gated cycles interleaved
        out_rdy = 1'b0;
        drive(CYCLE_VALID, 36'h1, 1'b1);
        chk("gated_vld_b1", out_vld, 0);
        drive(CYCLE_VALID, 36'h99, 1'b0);
        drive(CYCLE_VALID, 36'h2, 1'b1);
        drive(CYCLE_VALID, 36'h98, 1'b0);
        chk("gated_fill_mid", fill, 2);
        drive(CYCLE_VALID, 36'h3, 1'b1);
        drive(CYCLE_VALID, 36'h97, 1'b0);
        chk("gated_vld_b3", out_vld, 0);
        drive(CYCLE_DONE, 36'h4, 1'b1);
        chk("gated_vld_done", out_vld, 1);
        chk("gated_fill", fill, 4);
        out_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("gated_drain_vld", out_vld, 1);
            chk("gated_drain_dat", out_dat, 36'(i));
            chk("gated_drain_last", out_last, (i == 4) ? 1 : 0);
            idle();
        end
        chk("gated_empty", out_vld, 0);

        // two 8-beat transactions fill the buffer, a third is dropped
        out_rdy = 1'b0;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 8; i++) begin
                drive((i == 7) ? CYCLE_DONE : CYCLE_VALID, 36'(32'h100 + t * 8 + i), 1'b1);
            end
        end
        chk("full_fill", fill, 16);
        drive(CYCLE_VALID, 36'hBAD, 1'b1);
        chk("full_drop_pulse", drop_pulse, 1);
        chk("full_fill_kept", fill, 16);
        chk("full_state_drop", dut.state, ST_DROP);
        drive(CYCLE_VALID, 36'hBAD, 1'b1);
        chk("full_pulse_once", drop_pulse, 0);
        drive(CYCLE_DONE, 36'hBAD, 1'b1);
        chk("full_pulse_done", drop_pulse, 0);
        chk("full_state_idle", dut.state, ST_IDLE);
        chk("full_fill_after", fill, 16);
        out_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("full_drain_vld", out_vld, 1);
            chk("full_drain_dat", out_dat, 36'(32'h100 + k));
            chk("full_drain_last", out_last, ((k % 8) == 7) ? 1 : 0);
            idle();
        end
        chk("full_empty", out_vld, 0);

        // 9-beat transaction exceeds MAX_BEATS
        out_rdy = 1'b0;
        drive(CYCLE_DONE, 36'h77, 1'b1);
        chk("over_pre_fill", fill, 1);
        for (int i = 0; i < 8; i++) begin
            drive(CYCLE_VALID, 36'(32'h200 + i), 1'b1);
        end
        chk("over_fill_8", fill, 9);
        drive(CYCLE_DONE, 36'h2FF, 1'b1);
        chk("over_drop_pulse", drop_pulse, 1);
        chk("over_fill_rewound", fill, 1);
        chk("over_state_idle", dut.state, ST_IDLE);
        chk("over_drop_count", drop_count, STATS ? 16'd2 : 16'd0);
        out_rdy = 1'b1;
        chk("over_drain_dat", out_dat, 36'h77);
        chk("over_drain_last", out_last, 1);
        idle();
        chk("over_empty", out_vld, 0);

        // undefined cycle_type mid-COLLECT
        out_rdy = 1'b0;
        drive(CYCLE_VALID, 36'h31, 1'b1);
        drive(CYCLE_VALID, 36'h32, 1'b1);
        drive(CYCLE_TYPE_E'(2'd3), 36'hEE, 1'b1);
        chk("perr_pulse", protocol_err, 1);
        chk("perr_fill", fill, 2);
        chk("perr_state", dut.state, ST_COLLECT);
        idle();
        chk("perr_pulse_once", protocol_err, 0);
        drive(CYCLE_VALID, 36'h33, 1'b1);
        drive(CYCLE_DONE, 36'h34, 1'b1);
        chk("perr_fill_done", fill, 4);
        chk("perr_txn_count", txn_count, STATS ? 16'd6 : 16'd0);
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("perr_drain_dat", out_dat, 36'(32'h31 + i));
            chk("perr_drain_last", out_last, (i == 3) ? 1 : 0);
            idle();
        end
        chk("perr_empty", out_vld, 0);

        // asynchronous reset with committed and partial data buffered
        out_rdy = 1'b0;
        drive(CYCLE_DONE, 36'h41, 1'b1);
        drive(CYCLE_VALID, 36'h42, 1'b1);
        drive(CYCLE_VALID, 36'h43, 1'b1);
        chk("mrst_pre_fill", fill, 3);
        hero_in.cycle_type = CYCLE_IDLE;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_vld", out_vld, 0);
        chk("mrst_out_dat", out_dat, 0);
        chk("mrst_out_last", out_last, 0);
        chk("mrst_fill", fill, 0);
        chk("mrst_txn_count", txn_count, 0);
        chk("mrst_state", dut.state, ST_IDLE);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_rdy = 1'b1;
        drive(CYCLE_DONE, 36'h5A, 1'b1);
        chk("post_rst_vld", out_vld, 1);
        chk("post_rst_dat", out_dat, 36'h5A);
        chk("post_rst_last", out_last, 1);
        chk("post_rst_fill", fill, 1);
        idle();
        chk("post_rst_empty", out_vld, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
